sync_byte_aligner: RTL

- Sits directly downstream of the 8-bit serial-in shift register and consumes its parallel window every clock.
- Hunts for a sync byte in the window and locks byte alignment.
- Emits framed payload bytes with valid/start/end strobes, re-checks sync at every frame boundary, and drops lock after repeated misses (flywheel).

---
 rtl/sync_byte_aligner.sv | 106 ++++++++++
 1 files changed

// File: rtl/sync_byte_aligner.sv
// Byte aligner behind an MSB-first serial shift register.
// Hunts for a sync byte, frames payload and flywheels over missed syncs.
module sync_byte_aligner #(
  parameter logic [7:0] SYNC_BYTE  = 8'h47,
  parameter int         FRAME_LEN  = 4,
  parameter int         MISS_LIMIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] window,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       locked,
  output logic       sync_err
);

  localparam int BW = $clog2(FRAME_LEN + 1);
  localparam logic [BW-1:0] LAST = BW'(FRAME_LEN - 1);
  localparam logic [BW-1:0] ONE  = BW'(1);
  localparam logic [3:0]    MLIM = 4'(MISS_LIMIT);

  typedef enum logic [1:0] {
    SEARCH,
    PAYLOAD,
    CHECK
  } state_t;

  state_t          state;
  logic [2:0]      bit_cnt;
  logic [BW-1:0]   byte_cnt;
  logic [3:0]      miss_cnt;
  logic            hit;
  logic            slot;

  assign hit  = (window == SYNC_BYTE);
  // bit_cnt==7 means this edge is a multiple of 8 after the boundary
  assign slot = (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SEARCH;
      bit_cnt     <= 3'd0;
      byte_cnt    <= '0;
      miss_cnt    <= 4'd0;
      byte_data   <= 8'h00;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      sync_err    <= 1'b0;
      unique case (state)
        SEARCH: begin
          if (hit) begin
            state       <= PAYLOAD;
            frame_start <= 1'b1;
            locked      <= 1'b1;
            miss_cnt    <= 4'd0;
            bit_cnt     <= 3'd0;
            byte_cnt    <= '0;
          end
        end
        PAYLOAD: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (slot) begin
            byte_data  <= window;
            byte_valid <= 1'b1;
            byte_cnt   <= byte_cnt + ONE;
            if (byte_cnt == LAST) begin
              frame_end <= 1'b1;
              state     <= CHECK;
            end
          end
        end
        CHECK: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (slot) begin
            byte_cnt <= '0;
            if (hit) begin
              miss_cnt    <= 4'd0;
              frame_start <= 1'b1;
              state       <= PAYLOAD;
            end else begin
              sync_err <= 1'b1;
              miss_cnt <= miss_cnt + 4'd1;
              if ((miss_cnt + 4'd1) == MLIM) begin
                locked <= 1'b0;
                state  <= SEARCH;
              end else begin
                state <= PAYLOAD;
              end
            end
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule
